// File: rtl/diram_dfi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : diram_dfi_responder
//  Purpose  : DRAM-side end of a manager DFI link. Decodes cs/cmd/bank/addr,
//             keeps an open flag and row register per bank, absorbs write
//             data WRITE_LAT cycles after WR and returns read data on
//             phy__dfi__valid/phy__dfi__data READ_LAT cycles after RD.
//  Ports    : clk, reset_poweron (async, active-low)
//             dfi__phy__cs/cmd1/cmd0/bank/addr/data   command + write data in
//             phy__dfi__valid/phy__dfi__data          read response out
//             resp__sys__err/resp__sys__err_code      error pulse + held code
//  Options  : DIRAM_RESP_TRCD_CHECK_EN builds per-bank ACT->RD/WR spacing
//             counters that report code 4 on a tRCD violation.
//  Revision : 1.0 - initial release
// ============================================================================
module diram_dfi_responder #(
    parameter int BANK_W    = 5,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int CLK_GRP_W = 2,
    parameter int ROW_IDX_W = 2,
    parameter int COL_IDX_W = 3,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 1,
    parameter int TRCD      = 3
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    input  logic                 dfi__phy__cs,
    input  logic                 dfi__phy__cmd1,
    input  logic                 dfi__phy__cmd0,
    input  logic [BANK_W-1:0]    dfi__phy__bank,
    input  logic [ADDR_W-1:0]    dfi__phy__addr,
    input  logic [DATA_W-1:0]    dfi__phy__data,
    output logic [CLK_GRP_W-1:0] phy__dfi__valid,
    output logic [DATA_W-1:0]    phy__dfi__data,
    output logic                 resp__sys__err,
    output logic [2:0]           resp__sys__err_code
);

    localparam int IDX_W = BANK_W + ROW_IDX_W + COL_IDX_W;
    localparam int NBANK = 1 << BANK_W;
    localparam int DEPTH = 1 << IDX_W;

    // ---------------- command decode ----------------
    logic w_is_pre, w_is_act, w_is_rd, w_is_wr;
    assign w_is_pre = dfi__phy__cs & ~dfi__phy__cmd1 & ~dfi__phy__cmd0 & dfi__phy__addr[0];
    assign w_is_act = dfi__phy__cs & ~dfi__phy__cmd1 &  dfi__phy__cmd0;
    assign w_is_rd  = dfi__phy__cs &  dfi__phy__cmd1 & ~dfi__phy__cmd0;
    assign w_is_wr  = dfi__phy__cs &  dfi__phy__cmd1 &  dfi__phy__cmd0;

    // ---------------- bank table ----------------
    logic [NBANK-1:0]  open_q;
    logic [ADDR_W-1:0] row_q [NBANK];

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            open_q <= '0;
        end else if (w_is_act) begin
            open_q[dfi__phy__bank] <= 1'b1;
        end else if (w_is_pre) begin
            open_q[dfi__phy__bank] <= 1'b0;
        end
    end

    // Row registers need no reset: they are only meaningful while open.
    always_ff @(posedge clk) begin
        if (w_is_act) begin
            row_q[dfi__phy__bank] <= dfi__phy__addr;
        end
    end

    logic                 w_bank_open;
    logic [ADDR_W-1:0]    w_row;
    logic [IDX_W-1:0]     w_idx;
    assign w_bank_open = open_q[dfi__phy__bank];
    assign w_row       = row_q[dfi__phy__bank];
    assign w_idx       = {dfi__phy__bank, w_row[ROW_IDX_W-1:0], dfi__phy__addr[COL_IDX_W-1:0]};

    // Upper row bits are tracked but do not take part in the storage index.
    logic w_unused_row_bits;
    always_comb begin
        w_unused_row_bits = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            w_unused_row_bits = w_unused_row_bits ^ (^row_q[b][ADDR_W-1:ROW_IDX_W]);
        end
    end

    // ---------------- tRCD tracking (optional) ----------------
    logic w_trcd_busy;
`ifdef DIRAM_RESP_TRCD_CHECK_EN
    localparam int CNT_W = $clog2(TRCD) + 1;
    logic [CNT_W-1:0] trcd_q [NBANK];

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            for (int b = 0; b < NBANK; b++) trcd_q[b] <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (w_is_act && (dfi__phy__bank == BANK_W'(b))) begin
                    trcd_q[b] <= CNT_W'(TRCD - 1);
                end else if (trcd_q[b] != '0) begin
                    trcd_q[b] <= trcd_q[b] - 1'b1;
                end
            end
        end
    end
    assign w_trcd_busy = (trcd_q[dfi__phy__bank] != '0);
`else
    logic w_unused_trcd;
    assign w_unused_trcd = (TRCD > 0);
    assign w_trcd_busy   = 1'b0;
`endif

    // ---------------- error classification ----------------
    // Bank-state errors take precedence: a closed bank has no tRCD window.
    logic [2:0] w_err_code;
    always_comb begin
        w_err_code = 3'd0;
        if (w_is_act && w_bank_open)                      w_err_code = 3'd1;
        else if (w_is_rd && !w_bank_open)                 w_err_code = 3'd2;
        else if (w_is_wr && !w_bank_open)                 w_err_code = 3'd3;
        else if ((w_is_rd || w_is_wr) && w_trcd_busy)     w_err_code = 3'd4;
    end

    // ---------------- write pipe ----------------
    logic             w_wl_v;
    logic [IDX_W-1:0] w_wl_idx;

    generate
        if (WRITE_LAT > 0) begin : g_wr_pipe
            logic             wr_v_q   [1:WRITE_LAT];
            logic [IDX_W-1:0] wr_idx_q [1:WRITE_LAT];
            always_ff @(posedge clk or negedge reset_poweron) begin
                if (!reset_poweron) begin
                    for (int i = 1; i <= WRITE_LAT; i++) begin
                        wr_v_q[i]   <= 1'b0;
                        wr_idx_q[i] <= '0;
                    end
                end else begin
                    // Writes to a closed bank are dropped at entry.
                    wr_v_q[1]   <= w_is_wr & w_bank_open;
                    wr_idx_q[1] <= w_idx;
                    for (int i = 2; i <= WRITE_LAT; i++) begin
                        wr_v_q[i]   <= wr_v_q[i-1];
                        wr_idx_q[i] <= wr_idx_q[i-1];
                    end
                end
            end
            assign w_wl_v   = wr_v_q[WRITE_LAT];
            assign w_wl_idx = wr_idx_q[WRITE_LAT];
        end else begin : g_wr_direct
            assign w_wl_v   = w_is_wr & w_bank_open;
            assign w_wl_idx = w_idx;
        end
    endgenerate

    // ---------------- read pipe ----------------
    // Lookup happens in the cycle before the response register loads.
    logic             w_lk_v, w_lk_z;
    logic [IDX_W-1:0] w_lk_idx;

    generate
        if (READ_LAT > 1) begin : g_rd_pipe
            logic             rd_v_q   [1:READ_LAT-1];
            logic             rd_z_q   [1:READ_LAT-1];
            logic [IDX_W-1:0] rd_idx_q [1:READ_LAT-1];
            always_ff @(posedge clk or negedge reset_poweron) begin
                if (!reset_poweron) begin
                    for (int i = 1; i < READ_LAT; i++) begin
                        rd_v_q[i]   <= 1'b0;
                        rd_z_q[i]   <= 1'b0;
                        rd_idx_q[i] <= '0;
                    end
                end else begin
                    rd_v_q[1]   <= w_is_rd;
                    rd_z_q[1]   <= ~w_bank_open;
                    rd_idx_q[1] <= w_idx;
                    for (int i = 2; i < READ_LAT; i++) begin
                        rd_v_q[i]   <= rd_v_q[i-1];
                        rd_z_q[i]   <= rd_z_q[i-1];
                        rd_idx_q[i] <= rd_idx_q[i-1];
                    end
                end
            end
            assign w_lk_v   = rd_v_q[READ_LAT-1];
            assign w_lk_z   = rd_z_q[READ_LAT-1];
            assign w_lk_idx = rd_idx_q[READ_LAT-1];
        end else begin : g_rd_direct
            assign w_lk_v   = w_is_rd;
            assign w_lk_z   = ~w_bank_open;
            assign w_lk_idx = w_idx;
        end
    endgenerate

    // ---------------- storage (not reset) ----------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wl_v && reset_poweron) begin
            mem_q[w_wl_idx] <= dfi__phy__data;
        end
    end

    // Write-first forwarding when a write lands on the lookup cycle.
    logic [DATA_W-1:0] w_lk_data;
    assign w_lk_data = (w_wl_v && (w_wl_idx == w_lk_idx)) ? dfi__phy__data : mem_q[w_lk_idx];

    // ---------------- registered outputs ----------------
    logic              valid_q, err_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        err_code_q;

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            valid_q <= w_lk_v;
            data_q  <= (w_lk_v && !w_lk_z) ? w_lk_data : '0;
            err_q   <= (w_err_code != 3'd0);
            if (w_err_code != 3'd0) begin
                err_code_q <= w_err_code;
            end
        end
    end

    assign phy__dfi__valid     = {CLK_GRP_W{valid_q}};
    assign phy__dfi__data      = data_q;
    assign resp__sys__err      = err_q;
    assign resp__sys__err_code = err_code_q;

endmodule
`default_nettype wire
